timer_periph_mch: RTL and testbench
===================================

TIMER_PERIPH_MCH -- requirements
Module: timer_periph_mch

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 SHALL provide parameter CNT_W, default 32, counter and auto-reload width (legal 8..32).
REQ-003 SHALL provide parameter PSC_W, default 16, prescaler width (legal 1..16).
REQ-004 SHALL have port PCLK input 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port PRESET input 1, asynchronous active-low reset.
REQ-006 SHALL have port PADDR input 32, APB address; only bits [8:2] decoded.
REQ-007 SHALL have ports PWRITE, PENABLE, PSEL input 1 each, APB control.
REQ-008 SHALL have port PWDATA input 32, APB write data.
REQ-009 SHALL have port PRDATA output 32, APB read data.
REQ-010 SHALL have port PREADY output 1, APB transfer complete.
REQ-011 SHALL have port tick output NUM_CH, one-cycle per-channel wrap pulse.
REQ-012 SHALL have port irq output 1, OR of enabled pending channel interrupts.

Function
REQ-013 Register map: channel c at offset c*0x10; +0x0 CR, +0x4 PSC, +0x8 ARR, +0xC CNT; 0x100 ISR.
REQ-014 CR bits: [0] EN, [1] CLR (self-clearing, reads 0), [2] ONESHOT, [3] IRQEN; other bits read 0.
REQ-015 PSC SHALL be PSC_W bits, ARR and CNT CNT_W bits; unused upper PRDATA bits read 0.
REQ-016 ISR bit c = channel c pending; write-1-to-clear; bits >= NUM_CH read 0.
REQ-017 APB: zero wait state; PREADY = PSEL & PENABLE; write takes effect on that access-phase edge.
REQ-018 PRDATA valid whenever PSEL & PENABLE; 0 for unmapped offsets or channel index >= NUM_CH.
REQ-019 Writes to unmapped addresses SHALL be ignored with no side effect.
REQ-020 Per channel, while EN=1 the prescale counter SHALL count 0..PSC, then return to 0 issuing one prescaled tick.
REQ-021 PSC=0 SHALL give one prescaled tick every PCLK cycle.
REQ-022 On a prescaled tick, if CNT >= ARR then CNT SHALL become 0 (wrap event), else CNT SHALL increment by 1.
REQ-023 A wrap event SHALL pulse tick[c] high for exactly the cycle after the wrapping edge and set ISR[c].
REQ-024 ARR=0 SHALL produce a wrap event on every prescaled tick.
REQ-025 ONESHOT=1: wrap event SHALL clear EN on the same edge; CNT stays 0.
REQ-026 EN=0 SHALL freeze prescale counter and CNT; re-enable resumes from frozen values.
REQ-027 CR write with CLR=1 SHALL zero prescale counter and CNT on that edge, regardless of EN.
REQ-028 APB write to CNT SHALL load CNT and zero prescale counter, overriding any increment or wrap that edge.
REQ-029 ISR set by a wrap event SHALL win over a same-cycle W1C of that bit.
REQ-030 irq SHALL be registered: irq = OR over c of (ISR[c] & IRQEN[c]), one cycle after the cause.
REQ-031 Writing ARR below current CNT SHALL cause a wrap on the next prescaled tick (per REQ-022).

Reset
REQ-032 PRESET low SHALL asynchronously clear all CR, PSC, ARR, CNT, prescale counters and ISR to 0.
REQ-033 During and after reset: tick=0, irq=0, PRDATA=0, PREADY=0.
REQ-034 Reset asserted mid-count SHALL abort counting; no tick or ISR set on reset release.

Verification
REQ-035 Ch0 PSC=1, ARR=3, CR=0x1 -> CNT 0,0,1,1,2,2,3,3,0; tick[0] once per 8 cycles; ISR=0x1.
REQ-036 Ch2 PSC=0, ARR=0, CR=0xD (EN,ONESHOT,IRQEN) -> single tick[2] next cycle, CR reads 0xC, irq=1 one cycle later; ISR write 0x4 -> irq=0.
REQ-037 Ch1 running PSC=0 ARR=9; W1C ISR[1] on same edge as wrap -> ISR[1] remains 1.
REQ-038 Ch3 CNT=5, write CNT=0x20 with ARR=0x10 -> next tick wraps CNT to 0, tick[3] pulses.
REQ-039 Read offset 0x50 with NUM_CH=4 -> PRDATA=0; write ignored; PREADY=1 in access phase.
REQ-040 Assert PRESET low with ch0 CNT=7 -> all registers read 0, tick=0, irq=0 immediately and after release.

Source files
------------

// File: rtl/timer_periph_mch.sv
`timescale 1ns/1ps
// APB multi-channel timer: per-channel prescaler, auto-reload counter,
// one-shot mode, wrap tick pulses and a shared pending/interrupt register.
module timer_periph_mch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic [NUM_CH-1:0] tick,
  output logic              irq
);

  logic             access;
  logic             wr;
  logic             isr_hit;
  logic             ch_region;
  logic [3:0]       ch_idx;
  logic [1:0]       reg_idx;
  logic [NUM_CH-1:0] w1c;
  logic             unused_bits;

  logic [NUM_CH-1:0] sel, wr_cr, wr_psc, wr_arr, wr_cnt, clr, ptick, wrap;
  logic [NUM_CH-1:0] en, oneshot, irqen, isr;
  logic [PSC_W-1:0]  psc  [NUM_CH];
  logic [PSC_W-1:0]  pcnt [NUM_CH];
  logic [CNT_W-1:0]  arr  [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];

  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign ch_idx    = PADDR[7:4];
  assign reg_idx   = PADDR[3:2];
  assign ch_region = ~PADDR[8];
  assign isr_hit   = (PADDR[8:2] == 7'h40);
  assign w1c       = (wr && isr_hit) ? PWDATA[NUM_CH-1:0] : '0;
  assign PREADY    = access & PRESET;
  assign unused_bits = ^{PADDR[31:9], PADDR[1:0], PWDATA};

  // Channel indices >= NUM_CH never match, so those offsets are unmapped.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]    = ch_region && (ch_idx == 4'(c));
      wr_cr[c]  = wr && sel[c] && (reg_idx == 2'd0);
      wr_psc[c] = wr && sel[c] && (reg_idx == 2'd1);
      wr_arr[c] = wr && sel[c] && (reg_idx == 2'd2);
      wr_cnt[c] = wr && sel[c] && (reg_idx == 2'd3);
      clr[c]    = wr_cr[c] && PWDATA[1];
      ptick[c]  = en[c] && (pcnt[c] >= psc[c]);
      wrap[c]   = ptick[c] && (cnt[c] >= arr[c]) && !wr_cnt[c] && !clr[c];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access && PRESET) begin
      if (isr_hit) PRDATA[NUM_CH-1:0] = isr;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel[c]) begin
          case (reg_idx)
            2'd0:    PRDATA[3:0]       = {irqen[c], oneshot[c], 1'b0, en[c]};
            2'd1:    PRDATA[PSC_W-1:0] = psc[c];
            2'd2:    PRDATA[CNT_W-1:0] = arr[c];
            default: PRDATA[CNT_W-1:0] = cnt[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en      <= '0;
      oneshot <= '0;
      irqen   <= '0;
      isr     <= '0;
      tick    <= '0;
      irq     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        psc[c]  <= '0;
        pcnt[c] <= '0;
        arr[c]  <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_cr[c]) begin
          en[c]      <= PWDATA[0];
          oneshot[c] <= PWDATA[2];
          irqen[c]   <= PWDATA[3];
        end
        if (wr_psc[c]) psc[c] <= PWDATA[PSC_W-1:0];
        if (wr_arr[c]) arr[c] <= PWDATA[CNT_W-1:0];

        // Bus loads and clears take priority over counting on the same edge.
        if (wr_cnt[c]) begin
          cnt[c]  <= PWDATA[CNT_W-1:0];
          pcnt[c] <= '0;
        end else if (clr[c]) begin
          cnt[c]  <= '0;
          pcnt[c] <= '0;
        end else if (en[c]) begin
          if (ptick[c]) begin
            pcnt[c] <= '0;
            cnt[c]  <= wrap[c] ? '0 : cnt[c] + CNT_W'(1);
          end else begin
            pcnt[c] <= pcnt[c] + PSC_W'(1);
          end
        end

        if (wrap[c] && oneshot[c]) en[c] <= 1'b0;
      end

      // A wrap on the same edge as a write-1-to-clear keeps the bit set.
      isr  <= (isr & ~w1c) | wrap;
      tick <= wrap;
      irq  <= |(isr & irqen);
    end
  end

endmodule

// File: tb/tb_timer_periph_mch.sv
`timescale 1ns/1ps
// Directed APB bench for timer_periph_mch; reads and tick pulses are checked
// by monitors against expectation queues filled by the stimulus process.
module tb_timer_periph_mch;

  localparam int NUM_CH = 4;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [31:0]       PADDR = '0;
  logic              PWRITE = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PSEL = 1'b0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic [NUM_CH-1:0] tick;
  logic              irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [NUM_CH-1:0] tick_vec_q [$];
  int          tick_cyc_q [$];

  timer_periph_mch #(.NUM_CH(NUM_CH), .CNT_W(32), .PSC_W(16)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tick    (tick),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Read monitor: every access-phase cycle must be ready; reads pop the scoreboard.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) checkOutput("pready", 32'(PREADY), 32'h1);
    if (PSEL && PENABLE && !PWRITE) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_read: got 0x%08h required no read", PRDATA);
      end else begin
        checkOutput(rd_name_q.pop_front(), PRDATA, rd_exp_q.pop_front());
      end
    end
  end

  // Tick monitor: any nonzero tick must match the next expected pulse and cycle.
  always @(negedge PCLK) begin
    if (tick !== '0) begin
      if (tick_vec_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_tick: got 0x%0h at cycle %0d required none", tick, cyc);
      end else begin
        checkOutput("tick_vec", 32'(tick), 32'(tick_vec_q.pop_front()));
        checkOutput("tick_cycle", 32'(cyc), 32'(tick_cyc_q.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Holds the access phase for ten cycles, one PRDATA sample per cycle.
  task automatic read_stream(input string name, input logic [31:0] addr, input logic [31:0] exp [10]);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    for (int i = 0; i < 10; i++) begin
      rd_exp_q.push_back(exp[i]);
      rd_name_q.push_back(name);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (10) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic expect_tick(input logic [NUM_CH-1:0] vec, input int offset);
    tick_vec_q.push_back(vec);
    tick_cyc_q.push_back(cyc + offset);
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_tick"}, 32'(tick), 32'h0);
    checkOutput({tag, "_irq"}, 32'(irq), 32'h0);
    checkOutput({tag, "_pready"}, 32'(PREADY), 32'h0);
    checkOutput({tag, "_prdata"}, PRDATA, 32'h0);
  endtask

  initial begin
    logic [31:0] ch0_seq [10];
    ch0_seq = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0, 32'd1, 32'd1};

    $display("[TB] start");
    #2 PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 check_quiet("in_reset");
    @(posedge PCLK); #3 PRESET = 1'b1;
    #1 check_quiet("post_reset");
    apb_read("rst_cr0", 32'h00, 32'h0);
    apb_read("rst_psc1", 32'h14, 32'h0);
    apb_read("rst_arr2", 32'h28, 32'h0);
    apb_read("rst_cnt3", 32'h3C, 32'h0);
    apb_read("rst_isr", 32'h100, 32'h0);

    // Register widths and CR field masking.
    applyStimulus(32'h14, 32'h0001_2345);
    apb_read("psc1_width", 32'h14, 32'h0000_2345);
    applyStimulus(32'h18, 32'hDEAD_BEEF);
    apb_read("arr1_full", 32'h18, 32'hDEAD_BEEF);
    applyStimulus(32'h10, 32'hFFFF_FFF8);
    apb_read("cr1_mask", 32'h10, 32'h0000_0008);
    applyStimulus(32'h14, 32'h0);
    applyStimulus(32'h18, 32'd9);
    applyStimulus(32'h10, 32'h0);

    // Channel 0 prescaled count sequence, then freeze.
    applyStimulus(32'h04, 32'd1);
    applyStimulus(32'h08, 32'd3);
    applyStimulus(32'h00, 32'h1);
    expect_tick(4'b0001, 8);
    read_stream("ch0_cnt_seq", 32'h0C, ch0_seq);
    applyStimulus(32'h00, 32'h0);
    apb_read("ch0_isr", 32'h100, 32'h1);
    apb_read("ch0_frozen_cnt", 32'h0C, 32'd3);
    applyStimulus(32'h100, 32'h1);
    apb_read("ch0_isr_cleared", 32'h100, 32'h0);

    // Channel 2 one-shot with interrupt.
    applyStimulus(32'h28, 32'h0);
    applyStimulus(32'h20, 32'hD);
    expect_tick(4'b0100, 1);
    checkOutput("ch2_irq_t0", 32'(irq), 32'h0);
    @(posedge PCLK); #1 checkOutput("ch2_irq_t1", 32'(irq), 32'h0);
    @(posedge PCLK); #1 checkOutput("ch2_irq_t2", 32'(irq), 32'h1);
    apb_read("ch2_cr_after_oneshot", 32'h20, 32'hC);
    apb_read("ch2_cnt_after_oneshot", 32'h2C, 32'h0);
    apb_read("ch2_isr", 32'h100, 32'h4);
    applyStimulus(32'h100, 32'h4);
    checkOutput("ch2_irq_clear_t0", 32'(irq), 32'h1);
    @(posedge PCLK); #1 checkOutput("ch2_irq_clear_t1", 32'(irq), 32'h0);

    // Channel 1: clear ISR on the exact wrap edge.
    applyStimulus(32'h10, 32'h1);
    expect_tick(4'b0010, 10);
    repeat (7) @(posedge PCLK);
    applyStimulus(32'h100, 32'h2);
    apb_read("ch1_isr_set_wins", 32'h100, 32'h2);
    applyStimulus(32'h10, 32'h0);
    apb_read("ch1_frozen_cnt", 32'h1C, 32'd6);
    applyStimulus(32'h100, 32'h2);
    apb_read("ch1_isr_cleared", 32'h100, 32'h0);

    // Channel 3: counter loaded above ARR wraps on the next tick; CLR.
    applyStimulus(32'h38, 32'h10);
    applyStimulus(32'h3C, 32'd5);
    apb_read("ch3_cnt_load5", 32'h3C, 32'd5);
    applyStimulus(32'h3C, 32'h20);
    apb_read("ch3_cnt_load20", 32'h3C, 32'h20);
    applyStimulus(32'h30, 32'h1);
    expect_tick(4'b1000, 1);
    apb_read("ch3_cnt_after_wrap", 32'h3C, 32'd1);
    applyStimulus(32'h30, 32'h0);
    apb_read("ch3_cnt_frozen", 32'h3C, 32'd5);
    applyStimulus(32'h30, 32'h2);
    apb_read("ch3_cnt_clr", 32'h3C, 32'h0);
    apb_read("ch3_cr_clr_reads0", 32'h30, 32'h0);
    applyStimulus(32'h100, 32'h8);

    // Unmapped offsets.
    apb_read("unmapped_0x50", 32'h50, 32'h0);
    applyStimulus(32'h50, 32'hFFFF_FFFF);
    apb_read("unmapped_0x50_after_wr", 32'h50, 32'h0);
    apb_read("no_alias_cr1", 32'h10, 32'h0);
    apb_read("unmapped_0x104", 32'h104, 32'h0);
    apb_read("isr_after_unmapped", 32'h100, 32'h0);

    // Reset mid-count with an interrupt pending.
    applyStimulus(32'h20, 32'hD);
    expect_tick(4'b0100, 1);
    applyStimulus(32'h08, 32'h64);
    applyStimulus(32'h0C, 32'd7);
    applyStimulus(32'h00, 32'h1);
    repeat (3) @(posedge PCLK);
    #1 checkOutput("pre_reset_irq", 32'(irq), 32'h1);
    @(posedge PCLK); #3 PRESET = 1'b0;
    #1 check_quiet("mid_reset_now");
    repeat (2) @(negedge PCLK);
    check_quiet("mid_reset_held");
    @(posedge PCLK); #3 PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 check_quiet("after_release");
    apb_read("rst2_cr0", 32'h00, 32'h0);
    apb_read("rst2_psc0", 32'h04, 32'h0);
    apb_read("rst2_arr0", 32'h08, 32'h0);
    apb_read("rst2_cnt0", 32'h0C, 32'h0);
    apb_read("rst2_cr2", 32'h20, 32'h0);
    apb_read("rst2_isr", 32'h100, 32'h0);
    #1 checkOutput("rst2_irq", 32'(irq), 32'h0);

    repeat (5) @(posedge PCLK);
    checkOutput("rd_queue_empty", 32'(rd_exp_q.size()), 32'h0);
    checkOutput("tick_queue_empty", 32'(tick_vec_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
